// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - big-endian byte-addressable data RAM behind a fixed-latency valid/ready port
// One request outstanding; stores commit and loads sample on the accept edge.
module dmem_ctrl #(
  parameter int ADDR_W  = 14,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [31:0]       pend_rdata;
  logic              pend_err;
  logic [7:0]        mem [0:(1<<ADDR_W)-1];

  logic              accept;
  logic              err;
  logic [ADDR_W-1:0] a1, a2, a3;
  logic [7:0]        b0, b1, b2, b3;
  logic [31:0]       load_data;

  assign accept = req_valid & req_ready & rst_n;
  assign a1 = req_addr + ADDR_W'(1);
  assign a2 = req_addr + ADDR_W'(2);
  assign a3 = req_addr + ADDR_W'(3);
  assign b0 = mem[req_addr];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

  always_comb begin
    err = 1'b0;
    case (req_size)
      2'b01:   err = req_addr[0];
      2'b10:   err = (req_addr[1:0] != 2'b00);
      2'b11:   err = 1'b1;
      default: err = 1'b0;
    endcase
  end

  // Stores and errored requests answer with zero data
  always_comb begin
    load_data = '0;
    if (!req_we && !err) begin
      case (req_size)
        2'b00:   load_data = {{24{req_signed & b0[7]}}, b0};
        2'b01:   load_data = {{16{req_signed & b0[7]}}, b0, b1};
        default: load_data = {b0, b1, b2, b3};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept && req_we && !err) begin
      case (req_size)
        2'b00: mem[req_addr] <= req_wdata[7:0];
        2'b01: begin
          mem[req_addr] <= req_wdata[15:8];
          mem[a1]       <= req_wdata[7:0];
        end
        default: begin
          mem[req_addr] <= req_wdata[31:24];
          mem[a1]       <= req_wdata[23:16];
          mem[a2]       <= req_wdata[15:8];
          mem[a3]       <= req_wdata[7:0];
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      pend_rdata <= '0;
      pend_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          req_ready <= 1'b0;
          busy      <= 1'b1;
          if (LATENCY == 1) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= load_data;
            rsp_err   <= err;
          end else begin
            state      <= WAIT;
            cnt        <= 4'(LATENCY - 1);
            pend_rdata <= load_data;
            pend_err   <= err;
          end
        end
        WAIT: if (cnt <= 4'd1) begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= pend_rdata;
          rsp_err   <= pend_err;
        end else begin
          cnt <= cnt - 4'd1;
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - directed self-checking bench for dmem_ctrl
// Three instances (LATENCY 2, 3, 1) share request fields and reset; each has its own req_valid.
module tb_dmem_ctrl;
  logic        clk;
  logic        rst_n;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [13:0] req_addr;
  logic [31:0] req_wdata;
  logic        v1, v2, v3;
  logic        r1, r2, r3;
  logic        rv1, rv2, rv3;
  logic [31:0] rd1, rd2, rd3;
  logic        re1, re2, re3;
  logic        b1, b2, b3;

  int pass_cnt = 0;
  int total    = 0;

  dmem_ctrl #(.ADDR_W(14), .LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(v2), .req_ready(r2), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv2), .rsp_rdata(rd2), .rsp_err(re2), .busy(b2));

  dmem_ctrl #(.ADDR_W(14), .LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_ready(r3), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(re3), .busy(b3));

  dmem_ctrl #(.ADDR_W(14), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(r1), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(re1), .busy(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One request on the LATENCY=2 instance; lat is negedges from accept to rsp_valid (0 = none)
  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [13:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    int w;
    @(negedge clk);
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wd;
    w = 0;
    while (!r2 && w < 20) begin @(negedge clk); w++; end
    v2 = 1'b1;
    @(posedge clk); #1 v2 = 1'b0;
    lat = 0; rd = 32'hx; er = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rv2) begin lat = i; rd = rd2; er = re2; break; end
    end
    total++;
    if (lat !== 2) $display("FAIL req_latency addr=%h got=%0d exp=2", addr, lat); else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; v1 = 0; v2 = 0; v3 = 0;
    req_we = 0; req_size = 0; req_signed = 0; req_addr = 0; req_wdata = 0;
    repeat (3) @(negedge clk);
    total++;
    if ({rv2, b2, re2} !== 3'b000 || rd2 !== 32'h0)
      $display("FAIL reset_outputs got rv=%b busy=%b err=%b rdata=%h exp 0", rv2, b2, re2, rd2);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({r1, r2, r3} !== 3'b111) $display("FAIL reset_ready got=%b exp=111", {r1, r2, r3}); else pass_cnt++;
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    do_req(1, 2'b10, 0, 14'h010, 32'hDEADBEEF, rd, er, lat);
    total++;
    if (rd !== 32'h0 || er !== 1'b0) $display("FAIL sw_rsp got rdata=%h err=%b exp 0/0", rd, er); else pass_cnt++;
    do_req(0, 2'b10, 0, 14'h010, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) $display("FAIL lw got=%h err=%b exp=deadbeef/0", rd, er); else pass_cnt++;
    do_req(0, 2'b00, 0, 14'h010, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'h000000DE) $display("FAIL lbu_msb got=%h exp=000000de", rd); else pass_cnt++;
    do_req(0, 2'b00, 0, 14'h013, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'h000000EF) $display("FAIL lbu_lsb got=%h exp=000000ef", rd); else pass_cnt++;
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic er; int lat;
    do_req(1, 2'b10, 0, 14'h020, 32'h11223344, rd, er, lat);
    do_req(1, 2'b00, 0, 14'h021, 32'h00000080, rd, er, lat);
    do_req(0, 2'b00, 1, 14'h021, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'hFFFFFF80) $display("FAIL lb_signed got=%h exp=ffffff80", rd); else pass_cnt++;
    do_req(0, 2'b00, 0, 14'h021, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'h00000080) $display("FAIL lbu got=%h exp=00000080", rd); else pass_cnt++;
    do_req(0, 2'b10, 0, 14'h020, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'h11803344) $display("FAIL lw_after_sb got=%h exp=11803344", rd); else pass_cnt++;
  endtask

  task automatic test_half_err();
    logic [31:0] rd; logic er; int lat;
    do_req(1, 2'b10, 0, 14'h030, 32'hAABBCCDD, rd, er, lat);
    do_req(1, 2'b01, 0, 14'h030, 32'h00001234, rd, er, lat);
    do_req(0, 2'b01, 1, 14'h030, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'h00001234) $display("FAIL lh got=%h exp=00001234", rd); else pass_cnt++;
    do_req(0, 2'b01, 1, 14'h032, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'hFFFFCCDD) $display("FAIL lh_signed got=%h exp=ffffccdd", rd); else pass_cnt++;
    do_req(0, 2'b01, 0, 14'h032, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'h0000CCDD) $display("FAIL lhu got=%h exp=0000ccdd", rd); else pass_cnt++;
    do_req(0, 2'b10, 0, 14'h032, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'h0 || er !== 1'b1) $display("FAIL lw_misaligned got=%h err=%b exp=0/1", rd, er); else pass_cnt++;
    do_req(1, 2'b10, 0, 14'h032, 32'hFFFFFFFF, rd, er, lat);
    total++;
    if (er !== 1'b1) $display("FAIL sw_misaligned err got=%b exp=1", er); else pass_cnt++;
    do_req(0, 2'b01, 0, 14'h031, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'h0 || er !== 1'b1) $display("FAIL lh_odd got=%h err=%b exp=0/1", rd, er); else pass_cnt++;
    do_req(0, 2'b11, 0, 14'h030, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'h0 || er !== 1'b1) $display("FAIL size11 got=%h err=%b exp=0/1", rd, er); else pass_cnt++;
    do_req(0, 2'b10, 0, 14'h030, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'h1234CCDD || er !== 1'b0) $display("FAIL mem_unchanged got=%h err=%b exp=1234ccdd/0", rd, er); else pass_cnt++;
  endtask

  task automatic test_boundary();
    logic [31:0] rd; logic er; int lat;
    do_req(1, 2'b10, 0, 14'h3FFC, 32'hCAFEF00D, rd, er, lat);
    do_req(0, 2'b10, 0, 14'h3FFC, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'hCAFEF00D) $display("FAIL lw_top got=%h exp=cafef00d", rd); else pass_cnt++;
    do_req(0, 2'b00, 1, 14'h3FFF, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'h0000000D) $display("FAIL lb_top got=%h exp=0000000d", rd); else pass_cnt++;
  endtask

  task automatic test_latency();
    int pulses;
    @(negedge clk);
    req_we = 1; req_size = 2'b10; req_addr = 14'h0; req_wdata = 32'h0;
    v3 = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (rv3) pulses++;
      total++;
      if (r3 !== (i >= 4)) $display("FAIL lat3_ready n=%0d got=%b exp=%b", i, r3, (i >= 4)); else pass_cnt++;
      total++;
      if (rv3 !== (i == 3)) $display("FAIL lat3_valid n=%0d got=%b exp=%b", i, rv3, (i == 3)); else pass_cnt++;
      if (i == 3) v3 = 1'b0;
    end
    total++;
    if (pulses !== 1) $display("FAIL lat3_pulses got=%0d exp=1", pulses); else pass_cnt++;
    @(negedge clk);
    v1 = 1'b1;
    @(negedge clk);
    total++;
    if (rv1 !== 1'b1 || r1 !== 1'b0) $display("FAIL lat1_rsp got valid=%b ready=%b exp=1/0", rv1, r1); else pass_cnt++;
    v1 = 1'b0;
    @(negedge clk);
    total++;
    if (rv1 !== 1'b0 || r1 !== 1'b1) $display("FAIL lat1_idle got valid=%b ready=%b exp=0/1", rv1, r1); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat;
    logic [31:0] exp_d [4];
    int k, nrsp, last;
    logic acc;
    for (int i = 0; i < 4; i++) begin
      exp_d[i] = 32'hA0B0C000 | 32'(i);
      do_req(1, 2'b10, 0, 14'(14'h040 + 4 * i), exp_d[i], rd, er, lat);
    end
    @(negedge clk);
    req_we = 0; req_size = 2'b10; req_signed = 0; req_addr = 14'h040;
    v2 = 1'b1;
    k = 0; nrsp = 0; last = 0;
    for (int c = 0; c < 30; c++) begin
      if (rv2) begin
        total++;
        if (nrsp < 4 && rd2 !== exp_d[nrsp])
          $display("FAIL b2b_data idx=%0d got=%h exp=%h", nrsp, rd2, exp_d[nrsp]);
        else pass_cnt++;
        if (nrsp > 0) begin
          total++;
          if (c - last !== 3) $display("FAIL b2b_spacing idx=%0d got=%0d exp=3", nrsp, c - last); else pass_cnt++;
        end
        last = c;
        nrsp++;
      end
      acc = r2 & v2;
      @(posedge clk); #1;
      if (acc) begin
        k++;
        if (k == 4) v2 = 1'b0;
        else req_addr = 14'(14'h040 + 4 * k);
      end
      @(negedge clk);
    end
    total++;
    if (nrsp !== 4) $display("FAIL b2b_count got=%0d exp=4", nrsp); else pass_cnt++;
  endtask

  task automatic test_reset_midop();
    logic [31:0] rd; logic er; int lat;
    int pulses;
    @(negedge clk);
    req_we = 1; req_size = 2'b10; req_addr = 14'h050; req_wdata = 32'h5A5AA5A5;
    v2 = 1'b1;
    @(posedge clk); #1 v2 = 1'b0;
    @(negedge clk);
    total++;
    if (b2 !== 1'b1) $display("FAIL midop_busy got=%b exp=1", b2); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total++;
    if ({rv2, b2, re2, r2} !== 4'b0001 || rd2 !== 32'h0)
      $display("FAIL midop_reset got rv=%b busy=%b err=%b ready=%b rdata=%h exp 0/0/0/1/0", rv2, b2, re2, r2, rd2);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rv2) pulses++;
    end
    total++;
    if (pulses !== 0) $display("FAIL midop_dropped got=%0d pulses exp=0", pulses); else pass_cnt++;
    do_req(0, 2'b10, 0, 14'h050, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'h5A5AA5A5) $display("FAIL midop_store got=%h exp=5a5aa5a5", rd); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half_err();
    test_boundary();
    test_latency();
    test_back_to_back();
    test_reset_midop();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
